fetch_scheduler: RTL and testbench

Sequencer in front of the PE fetch stage. It accepts one layer-tile configuration over a rdy/ack channel, then walks the pixel × weight-tile × input-tile loop nest. For each loop step it emits one FSpipein control token plus input, weight and psum buffer addresses, over a rdy/ack channel into the fetch stage MAIN port. It pulses done when the last token is accepted, and returns to idle.

---
 rtl/fetch_scheduler_pkg.sv | 66 ++++++
 rtl/fetch_loop_cnt.sv | 61 ++++++
 rtl/fetch_scheduler.sv | 148 ++++++++++++++
 tb/tb_fetch_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_scheduler_pkg.sv
// Shared PE control types for the fetch scheduler and the fetch stage.
//   - Configuration handed to the scheduler (FSschedCfg).
//   - Control token passed to the fetch stage MAIN port (FSpipein), which
//     bundles the fsctl / msconf / ssctl / ssppctl sub-fields.
// Counter widths are fixed here because they size the packed structs.
package fetch_scheduler_pkg;

  localparam int TCNT_W     = 4;  // iNumT / wNumT counter width
  localparam int PIX_W      = 8;  // pixel counter width
  localparam int FS_IADDR_W = 6;  // default input-buffer address width
  localparam int FS_WADDR_W = 6;  // default weight-buffer address width
  localparam int FS_PADDR_W = 7;  // default psum-buffer address width

  typedef enum logic {
    PSUM_D16 = 1'b0,
    PSUM_D32 = 1'b1
  } psum_mode_e;

  typedef enum logic [1:0] {
    MODE_CONV   = 2'd0,
    MODE_DWCONV = 2'd1,
    MODE_FC     = 2'd2,
    MODE_POOL   = 2'd3
  } pe_mode_e;

  typedef struct packed {
    pe_mode_e          mode;
    logic [TCNT_W-1:0] iNumT;
    logic [TCNT_W-1:0] wNumT;
    psum_mode_e        psum_mode;
    logic [PIX_W-1:0]  nPix;
  } FSschedCfg;

  typedef struct packed {
    psum_mode_e psum_mode;
    logic       psum_parity;
  } FSctl;

  typedef struct packed {
    pe_mode_e          mode;
    logic [TCNT_W-1:0] iNumT;
    logic [TCNT_W-1:0] wNumT;
  } MSconf;

  typedef struct packed {
    logic acc_first;
    logic acc_last;
  } SSctl;

  typedef struct packed {
    logic wb_en;
  } PPctl;

  typedef struct packed {
    FSctl  fsctl;
    MSconf msconf;
    SSctl  ssctl;
    PPctl  ssppctl;
  } FSpipein;

  // A loop nest with any zero bound issues no tokens at all.
  function automatic logic is_empty_nest(input FSschedCfg c);
    return (c.nPix == '0) || (c.iNumT == '0) || (c.wNumT == '0);
  endfunction

endpackage

// File: rtl/fetch_loop_cnt.sv
// Three-level nested loop counter: pixel (outer) x weight tile x input tile
// (inner).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clr                   synchronous clear of all three counters
//   adv                   advance the nest by one inner step
//   itile_num/wtile_num/pix_num  per-level bounds (must be nonzero when adv)
//   itile/wtile/pix       current counter values
//   itile_wrap/wtile_wrap inner / middle level at its last value
//   last                  whole nest at its final step
module fetch_loop_cnt
  import fetch_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  input  logic [TCNT_W-1:0] itile_num,
  input  logic [TCNT_W-1:0] wtile_num,
  input  logic [PIX_W-1:0]  pix_num,
  output logic [TCNT_W-1:0] itile,
  output logic [TCNT_W-1:0] wtile,
  output logic [PIX_W-1:0]  pix,
  output logic              itile_wrap,
  output logic              wtile_wrap,
  output logic              last
);

  logic pix_wrap;

  assign itile_wrap = (itile == itile_num - 1'b1);
  assign wtile_wrap = (wtile == wtile_num - 1'b1);
  assign pix_wrap   = (pix == pix_num - 1'b1);
  assign last       = itile_wrap && wtile_wrap && pix_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      itile <= '0;
      wtile <= '0;
      pix   <= '0;
    end else if (clr) begin
      itile <= '0;
      wtile <= '0;
      pix   <= '0;
    end else if (adv) begin
      if (itile_wrap) begin
        itile <= '0;
        if (wtile_wrap) begin
          wtile <= '0;
          // The final step wraps everything back to zero.
          pix   <= pix_wrap ? '0 : pix + 1'b1;
        end else begin
          wtile <= wtile + 1'b1;
        end
      end else begin
        itile <= itile + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_scheduler.sv
// Fetch scheduler: accepts one layer-tile configuration, then walks the
// pixel x weight-tile x input-tile loop nest and emits one control token plus
// input / weight / psum buffer addresses per step to the fetch stage.
// Optional build macro: FSSCHED_STALL_CNT_EN adds o_stall_cnt, a saturating
// count of cycles where a token is offered but not accepted.
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_CFG_rdy/o_CFG_ack   configuration handshake, payload i_cfg
//   o_MAIN_rdy/i_MAIN_ack token handshake, payload o_pipe and addresses
//   o_ip_addr/o_wp_addr/o_pp_addr  buffer read addresses
//   o_busy                high while walking the loop nest
//   o_done                one-cycle pulse after the last token transfer
//   o_stall_cnt           (FSSCHED_STALL_CNT_EN only) stall cycle count
module fetch_scheduler
  import fetch_scheduler_pkg::*;
#(
  parameter int IADDR_W = FS_IADDR_W,
  parameter int WADDR_W = FS_WADDR_W,
  parameter int PADDR_W = FS_PADDR_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_CFG_rdy,
  output logic               o_CFG_ack,
  input  FSschedCfg          i_cfg,
  output logic               o_MAIN_rdy,
  input  logic               i_MAIN_ack,
  output FSpipein            o_pipe,
  output logic [IADDR_W-1:0] o_ip_addr,
  output logic [WADDR_W-1:0] o_wp_addr,
  output logic [PADDR_W-1:0] o_pp_addr,
  output logic               o_busy,
`ifdef FSSCHED_STALL_CNT_EN
  output logic [15:0]        o_stall_cnt,
`endif
  output logic               o_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int WP_W = 2 * TCNT_W + 1;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  FSschedCfg         cfg_q;
  logic              cfg_xfer;
  logic              main_xfer;
  logic [TCNT_W-1:0] itile;
  logic [TCNT_W-1:0] wtile;
  logic [PIX_W-1:0]  pix;
  logic              itile_wrap;
  logic              wtile_wrap;
  logic              last;
  logic [WP_W-1:0]   wp_full;
  logic [PIX_W-1:0]  pp_full;

  assign cfg_xfer  = (state == S_IDLE) && i_CFG_rdy;
  assign main_xfer = (state == S_RUN) && i_MAIN_ack;

  fetch_loop_cnt u_loop (
    .clk        (i_clk),
    .rst_n      (i_rst),
    .clr        (cfg_xfer),
    .adv        (main_xfer),
    .itile_num  (cfg_q.iNumT),
    .wtile_num  (cfg_q.wNumT),
    .pix_num    (cfg_q.nPix),
    .itile      (itile),
    .wtile      (wtile),
    .pix        (pix),
    .itile_wrap (itile_wrap),
    .wtile_wrap (wtile_wrap),
    .last       (last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (cfg_xfer) state_nxt = is_empty_nest(i_cfg) ? S_DONE : S_RUN;
      S_RUN:  if (main_xfer && last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= S_IDLE;
      cfg_q <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_xfer) cfg_q <= i_cfg;
    end
  end

  // Address arithmetic uses only registered counters and config, so the ack
  // input reaches the outputs only through the state register.
  assign wp_full = WP_W'(wtile) * WP_W'(cfg_q.iNumT) + WP_W'(itile);
  assign pp_full = (cfg_q.psum_mode == PSUM_D16) ? (pix >> 1) : pix;

  // Gating on i_rst keeps the ack low while reset is asserted even if the
  // requester is already raising i_CFG_rdy.
  assign o_CFG_ack = i_rst && cfg_xfer;
  assign o_busy    = (state == S_RUN);
  assign o_done    = (state == S_DONE);

  // Token and addresses are forced to zero outside RUN.
  always_comb begin
    o_MAIN_rdy = 1'b0;
    o_pipe     = '0;
    o_ip_addr  = '0;
    o_wp_addr  = '0;
    o_pp_addr  = '0;
    if (state == S_RUN) begin
      o_MAIN_rdy                = 1'b1;
      o_pipe.msconf.mode        = cfg_q.mode;
      o_pipe.msconf.iNumT       = cfg_q.iNumT;
      o_pipe.msconf.wNumT       = cfg_q.wNumT;
      o_pipe.fsctl.psum_mode    = cfg_q.psum_mode;
      o_pipe.fsctl.psum_parity  = (cfg_q.psum_mode == PSUM_D16) ? pix[0] : 1'b0;
      o_pipe.ssctl.acc_first    = (wtile == '0) && (itile == '0);
      o_pipe.ssctl.acc_last     = wtile_wrap && itile_wrap;
      o_pipe.ssppctl.wb_en      = wtile_wrap && itile_wrap;
      o_ip_addr                 = IADDR_W'(itile);
      o_wp_addr                 = WADDR_W'(wp_full);
      o_pp_addr                 = PADDR_W'(pp_full);
    end
  end

`ifdef FSSCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_cnt <= '0;
    end else if (cfg_xfer) begin
      stall_cnt <= '0;
    end else if ((state == S_RUN) && !i_MAIN_ack && (stall_cnt != 16'hffff)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_scheduler.sv
// Scoreboard bench for fetch_scheduler. Stimulus pushes the expected token
// stream for each configuration into a queue; a monitor compares every
// offered token against the queue head and pops it on transfer.
module tb_fetch_scheduler;
  import fetch_scheduler_pkg::*;

  typedef struct packed {
    FSpipein                pipe;
    logic [FS_IADDR_W-1:0]  ip;
    logic [FS_WADDR_W-1:0]  wp;
    logic [FS_PADDR_W-1:0]  pp;
  } exp_t;

  logic                  i_clk;
  logic                  i_rst;
  logic                  i_CFG_rdy;
  logic                  o_CFG_ack;
  FSschedCfg             i_cfg;
  logic                  o_MAIN_rdy;
  logic                  i_MAIN_ack;
  FSpipein               o_pipe;
  logic [FS_IADDR_W-1:0] o_ip_addr;
  logic [FS_WADDR_W-1:0] o_wp_addr;
  logic [FS_PADDR_W-1:0] o_pp_addr;
  logic                  o_busy;
  logic                  o_done;
`ifdef FSSCHED_STALL_CNT_EN
  logic [15:0]           o_stall_cnt;
`endif

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  int   stall_seen;
  int   ack_mode;   // 0: low, 1: high, 2: random 50%

  fetch_scheduler dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_CFG_rdy  (i_CFG_rdy),
    .o_CFG_ack  (o_CFG_ack),
    .i_cfg      (i_cfg),
    .o_MAIN_rdy (o_MAIN_rdy),
    .i_MAIN_ack (i_MAIN_ack),
    .o_pipe     (o_pipe),
    .o_ip_addr  (o_ip_addr),
    .o_wp_addr  (o_wp_addr),
    .o_pp_addr  (o_pp_addr),
    .o_busy     (o_busy),
`ifdef FSSCHED_STALL_CNT_EN
    .o_stall_cnt(o_stall_cnt),
`endif
    .o_done     (o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Ack driver: single process, mode selected by stimulus.
  initial begin
    i_MAIN_ack = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      case (ack_mode)
        0:       i_MAIN_ack = 1'b0;
        1:       i_MAIN_ack = 1'b1;
        default: i_MAIN_ack = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: every offered token is compared against the queue head, so a
  // stalled token is re-checked each stall cycle (stability).
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst && o_MAIN_rdy) begin
        if (!i_MAIN_ack) stall_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_token", 64'(o_MAIN_rdy), 64'(0));
        end else begin
          e = exp_q[0];
          check("pipe", 64'(o_pipe), 64'(e.pipe));
          check("ip_addr", 64'(o_ip_addr), 64'(e.ip));
          check("wp_addr", 64'(o_wp_addr), 64'(e.wp));
          check("pp_addr", 64'(o_pp_addr), 64'(e.pp));
          if (i_MAIN_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Expected token stream: plain nested loops over the configured bounds.
  task automatic push_run(input FSschedCfg c);
    exp_t e;
    for (int p = 0; p < int'(c.nPix); p++)
      for (int w = 0; w < int'(c.wNumT); w++)
        for (int i = 0; i < int'(c.iNumT); i++) begin
          e = '0;
          e.pipe.msconf.mode       = c.mode;
          e.pipe.msconf.iNumT      = c.iNumT;
          e.pipe.msconf.wNumT      = c.wNumT;
          e.pipe.fsctl.psum_mode   = c.psum_mode;
          e.pipe.fsctl.psum_parity = (c.psum_mode == PSUM_D16) ? p[0] : 1'b0;
          e.pipe.ssctl.acc_first   = (w == 0) && (i == 0);
          e.pipe.ssctl.acc_last    = (w == int'(c.wNumT) - 1) && (i == int'(c.iNumT) - 1);
          e.pipe.ssppctl.wb_en     = e.pipe.ssctl.acc_last;
          e.ip = FS_IADDR_W'(i);
          e.wp = FS_WADDR_W'((w * int'(c.iNumT) + i) % 64);
          e.pp = FS_PADDR_W'(((c.psum_mode == PSUM_D16) ? p / 2 : p) % 128);
          exp_q.push_back(e);
        end
  endtask

  function automatic FSschedCfg mk_cfg(input int it, input int wt, input int np,
                                       input psum_mode_e pm, input pe_mode_e md);
    FSschedCfg c;
    c.mode      = md;
    c.iNumT     = TCNT_W'(it);
    c.wNumT     = TCNT_W'(wt);
    c.psum_mode = pm;
    c.nPix      = PIX_W'(np);
    return c;
  endfunction

  // Present a config; returns #1 after the accepting edge.
  task automatic start_cfg(input FSschedCfg c);
    @(posedge i_clk);
    #1;
    i_cfg     = c;
    i_CFG_rdy = 1'b1;
    #1;
    check("cfg_ack_idle", 64'(o_CFG_ack), 64'(1));
    @(posedge i_clk);
    #1;
    i_CFG_rdy = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!o_done && n < limit) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("done_seen", 64'(o_done), 64'(1));
  endtask

  task automatic run_cfg(input FSschedCfg c, input int limit);
    int ntok;
    ntok = int'(c.nPix) * int'(c.wNumT) * int'(c.iNumT);
    push_run(c);
    start_cfg(c);
    check("busy_after_cfg", 64'(o_busy), 64'(ntok != 0));
    wait_done(limit);
    check("no_rdy_at_done", 64'(o_MAIN_rdy), 64'(0));
    check("tokens_left", 64'(exp_q.size()), 64'(0));
    @(posedge i_clk);
    #1;
    check("done_one_cycle", 64'(o_done), 64'(0));
    check("idle_not_busy", 64'(o_busy), 64'(0));
  endtask

  initial begin
    FSschedCfg c;
    int base;
    vectors     = 0;
    miscompares = 0;
    stall_seen  = 0;
    ack_mode    = 1;
    i_CFG_rdy   = 1'b1;
    i_cfg       = mk_cfg(2, 2, 2, PSUM_D32, MODE_CONV);
    i_rst       = 1'b1;
    #2 i_rst    = 1'b0;
    #1;
    check("rst_cfg_ack", 64'(o_CFG_ack), 64'(0));
    check("rst_main_rdy", 64'(o_MAIN_rdy), 64'(0));
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_done", 64'(o_done), 64'(0));
    check("rst_pipe", 64'(o_pipe), 64'(0));
    check("rst_addrs", 64'({o_ip_addr, o_wp_addr, o_pp_addr}), 64'(0));
    i_CFG_rdy = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1 i_rst = 1'b1;

    // D32, 2x2x2, ack held high: 8 back-to-back tokens.
    run_cfg(mk_cfg(2, 2, 2, PSUM_D32, MODE_CONV), 20);

    // D16, 4 pixels: parity toggles per pixel, psum address pix>>1.
    run_cfg(mk_cfg(2, 2, 4, PSUM_D16, MODE_FC), 30);

    // Random ack, 3x1x3: stability of held tokens and stall count.
    ack_mode = 2;
    base = stall_seen;
    run_cfg(mk_cfg(3, 1, 3, PSUM_D32, MODE_DWCONV), 200);
    ack_mode = 1;
`ifdef FSSCHED_STALL_CNT_EN
    check("stall_cnt", 64'(o_stall_cnt), 64'(stall_seen - base));
`endif

    // Empty nest: accepted, no tokens, done right away.
    run_cfg(mk_cfg(0, 2, 2, PSUM_D32, MODE_CONV), 5);

    // Reset after 3 of 8 transfers, then a clean full run.
    c = mk_cfg(2, 2, 2, PSUM_D32, MODE_POOL);
    push_run(c);
    start_cfg(c);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    #1;
    check("abort_main_rdy", 64'(o_MAIN_rdy), 64'(0));
    check("abort_busy", 64'(o_busy), 64'(0));
    check("abort_done", 64'(o_done), 64'(0));
    check("abort_pipe", 64'(o_pipe), 64'(0));
    check("abort_addrs", 64'({o_ip_addr, o_wp_addr, o_pp_addr}), 64'(0));
    check("abort_left", 64'(exp_q.size()), 64'(5));
    exp_q.delete();
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    run_cfg(c, 20);

    // CFG held high through RUN: ack blocked until IDLE, then second cfg.
    c = mk_cfg(2, 2, 2, PSUM_D32, MODE_CONV);
    push_run(c);
    push_run(mk_cfg(1, 1, 2, PSUM_D16, MODE_FC));
    start_cfg(c);
    i_CFG_rdy = 1'b1;
    i_cfg     = mk_cfg(1, 1, 2, PSUM_D16, MODE_FC);
    for (int k = 0; k < 20 && !o_done; k++) begin
      check("cfg_ack_run", 64'(o_CFG_ack), 64'(0));
      @(posedge i_clk);
      #1;
    end
    check("done_seen_a", 64'(o_done), 64'(1));
    check("cfg_ack_done", 64'(o_CFG_ack), 64'(0));
    @(posedge i_clk);
    #1;
    check("cfg_ack_after_done", 64'(o_CFG_ack), 64'(1));
    @(posedge i_clk);
    #1;
    i_CFG_rdy = 1'b0;
    check("busy_second", 64'(o_busy), 64'(1));
    wait_done(10);
    check("tokens_left_b", 64'(exp_q.size()), 64'(0));
    @(posedge i_clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
